// File: rtl/alu_iterative.sv
// Multi-cycle ALU: single-cycle add/sub/and/or/slt, iterative 1-bit-per-cycle shifts.
// One request per in_valid/in_ready handshake; the result is held in DONE until out_ready.
module alu_iterative #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       alu_ctrl,
    input  logic             branch_neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             branch_taken
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic               bneg_q, bneg_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               bt_q, bt_d;

    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   shift_res;
    logic               load;
    logic [WIDTH-1:0]   fin;
    logic               fin_bneg;
    logic               fin_zero;

    assign shamt    = op_b[SHAMT_W-1:0];
    assign is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);

    // Single-cycle ops; a shift only reaches here with shamt==0, so it passes op_a through.
    always_comb begin
        alu_res = op_a;
        case (alu_ctrl)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu_res = op_a;
        endcase
    end

    always_comb begin
        shift_res = acc_q;
        case (ctrl_q)
            OP_SLL:  shift_res = {acc_q[WIDTH-2:0], 1'b0};
            OP_SRL:  shift_res = {1'b0, acc_q[WIDTH-1:1]};
            OP_SRA:  shift_res = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default: shift_res = acc_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ctrl_d   = ctrl_q;
        bneg_d   = bneg_q;
        load     = 1'b0;
        fin      = alu_res;
        fin_bneg = branch_neg;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d  = op_a;
                    cnt_d  = shamt;
                    ctrl_d = alu_ctrl;
                    bneg_d = branch_neg;
                    if (is_shift && (shamt != '0)) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                        load    = 1'b1;
                    end
                end
            end
            SHIFT: begin
                acc_d = shift_res;
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d  = DONE;
                    load     = 1'b1;
                    fin      = shift_res;
                    fin_bneg = bneg_q;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result and flags only update when an op completes, so they hold while not valid.
    always_comb begin
        fin_zero = (fin == '0);
        result_d = result_q;
        zero_d   = zero_q;
        bt_d     = bt_q;
        if (load) begin
            result_d = fin;
            zero_d   = fin_zero;
            bt_d     = fin_bneg ? fin_zero : ~fin_zero;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            ctrl_q   <= '0;
            bneg_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            bt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ctrl_q   <= ctrl_d;
            bneg_q   <= bneg_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            bt_q     <= bt_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign result       = result_q;
    assign zero         = zero_q;
    assign branch_taken = bt_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Directed bench for alu_iterative: latency, arithmetic, flags, backpressure, async reset.
module tb_alu_iterative;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0]  alu_ctrl;
    logic        branch_neg;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        branch_taken;

    int errs  = 0;
    int nchk  = 0;

    alu_iterative #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .alu_ctrl     (alu_ctrl),
        .branch_neg   (branch_neg),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .zero         (zero),
        .branch_taken (branch_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present a request at a negedge; it is accepted on the following posedge.
    task automatic issue(input string tag, input logic [2:0] ctrl, input logic [31:0] a,
                         input logic [31:0] b, input logic bneg);
        @(negedge clk);
        chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
        alu_ctrl   = ctrl;
        op_a       = a;
        op_b       = b;
        branch_neg = bneg;
        in_valid   = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Latency counts edges after the accept edge until out_valid is seen.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_out(input string tag, input logic [31:0] exp_res, input logic exp_bt);
        chk({tag, ".result"}, result, exp_res);
        chk({tag, ".zero"}, {31'b0, zero}, {31'b0, (exp_res == 32'd0)});
        chk({tag, ".branch_taken"}, {31'b0, branch_taken}, {31'b0, exp_bt});
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, ".in_ready_after"}, {31'b0, in_ready}, 32'd1);
        chk({tag, ".out_valid_after"}, {31'b0, out_valid}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [2:0] ctrl, input logic [31:0] a,
                       input logic [31:0] b, input logic bneg, input logic [31:0] exp_res,
                       input logic exp_bt, input int exp_lat);
        issue(tag, ctrl, a, b, bneg);
        wait_done(tag, exp_lat);
        check_out(tag, exp_res, exp_bt);
        take(tag);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        op_a       = '0;
        op_b       = '0;
        alu_ctrl   = '0;
        branch_neg = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.zero", {31'b0, zero}, 32'd1);
        chk("rst.branch_taken", {31'b0, branch_taken}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("add",     3'b000, 32'd7,        32'd5,        1'b0, 32'd12,       1'b1, 1);
        run("beq_eq",  3'b001, 32'h1234,     32'h1234,     1'b1, 32'd0,        1'b1, 1);
        run("beq_ne",  3'b001, 32'h1234,     32'h1235,     1'b1, 32'hFFFFFFFF, 1'b0, 1);
        run("blt",     3'b101, 32'hFFFFFFFF, 32'd1,        1'b0, 32'd1,        1'b1, 1);
        run("bge",     3'b101, 32'd1,        32'hFFFFFFFF, 1'b1, 32'd0,        1'b1, 1);
        run("and",     3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'h00F000F0, 1'b1, 1);
        run("or",      3'b011, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'hFFF0FFF0, 1'b1, 1);
        run("sra4",    3'b111, 32'h80000000, 32'h24,       1'b0, 32'hF8000000, 1'b1, 5);
        run("sll0",    3'b100, 32'hDEADBEEF, 32'h20,       1'b0, 32'hDEADBEEF, 1'b1, 1);
        run("sll31",   3'b100, 32'd1,        32'd31,       1'b0, 32'h80000000, 1'b1, 32);

        // Backpressure: srl result must hold, and in_valid pulses must be ignored.
        issue("srl_bp", 3'b110, 32'h80000001, 32'd3, 1'b1);
        wait_done("srl_bp", 4);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            op_a     = 32'd100 + 32'(i);
            op_b     = 32'd1;
            alu_ctrl = 3'b000;
            @(posedge clk);
            #1;
            chk("bp.result", result, 32'h10000000);
            chk("bp.zero", {31'b0, zero}, 32'd0);
            chk("bp.branch_taken", {31'b0, branch_taken}, 32'd0);
            chk("bp.in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp.out_valid", {31'b0, out_valid}, 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        take("srl_bp");
        @(negedge clk);
        chk("bp.no_stale_accept", {31'b0, out_valid}, 32'd0);

        // Async reset in the middle of a 20-step shift.
        issue("rst_mid", 3'b100, 32'h3, 32'd20, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid.in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_mid.result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) begin
            @(negedge clk);
            chk("rst_mid.no_out_valid", {31'b0, out_valid}, 32'd0);
        end
        run("add_post", 3'b000, 32'hFFFFFFFF, 32'd1, 1'b1, 32'd0, 1'b1, 1);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
